xnor_correlator: RTL and testbench
==================================

Name: xnor_correlator

Overview:
Parametrised streaming XNOR correlator. Shifts a serial bit stream into a WIDTH-bit window, XNORs the window against a programmable pattern and registers the agreement count (popcount of the XNOR). It flags a match when the count reaches THRESH and keeps a saturating match counter. It is the sequential, width-generic successor to the team's single-bit XNOR gate, and sits in front of sync-word / preamble detection logic.

Parameters:
WIDTH, 8, window and pattern length in bits; legal range 2 to 64.
THRESH, WIDTH, minimum agreement count for a match; legal range 1 to WIDTH. The default means an exact match.
CNT_W, 16, width of the saturating match counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of the window and the match counter
pattern_load  input  1  capture pattern_in this cycle
pattern_in  input  WIDTH  reference pattern; MSB is compared against the oldest bit
in_valid  input  1  in_bit is accepted this cycle
in_bit  input  1  serial data bit
out_valid  output  1  score and match are valid this cycle (one-cycle pulse per accepted bit once the window is full)
score  output  SW  agreement count 0..WIDTH, where SW = $clog2(WIDTH+1)
match  output  1  score >= THRESH, qualified by out_valid
match_count  output  CNT_W  number of matches since reset/clear; saturates
window_full  output  1  window holds WIDTH valid bits

Behaviour:
- Reset (rst_n low, asynchronous): window, pattern, fill, score, match_count = 0; out_valid, match, window_full = 0; state = EMPTY.
- Window: on an accepted bit, win <= {win[WIDTH-2:0], in_bit}. The newest bit is win[0]; the oldest is win[WIDTH-1].
- Fill state machine, with fill counter 0..WIDTH:
  - EMPTY: on accept, fill = 1, go to FILLING.
  - FILLING: on accept, increment fill; go to FULL when fill reaches WIDTH.
  - FULL: stays FULL on accept.
  - Any state goes to EMPTY on clear.
- window_full = (state == FULL), registered.
- Latency 1:
  - The cycle after an accept that leaves the window full (including the accept that fills it), out_valid = 1.
  - score = popcount(~(win_next ^ pat_cur)), where win_next includes the new bit.
  - match = (score >= THRESH).
  - Otherwise out_valid = 0 and match = 0; score holds its last value.
- in_valid low: no shift and no output pulse. Gaps of any length are legal.
- match_count increments in the same cycle match is registered high. At 2^CNT_W - 1 it holds (no wrap).
- pattern_load:
  - pat <= pattern_in on the next edge.
  - It does not flush the window.
  - If it coincides with an accept, that bit is scored against the OLD pattern; the new pattern applies from the next accept.
- clear:
  - Takes priority over in_valid in the same cycle; the bit is discarded.
  - Sets fill = 0, match_count = 0, out_valid = 0, match = 0.
  - Does not alter pat or score.
- clear together with pattern_load: both take effect.
- Arithmetic: the popcount is computed at full SW width, and the comparison with THRESH is unsigned at SW width. There is no truncation.
- Reset asserted mid-stream: all state returns to its reset values immediately. The first out_valid after release comes no earlier than WIDTH accepts later.

Decomposition:
- Shared package xnor_pkg:
  - fill_state_t enum {EMPTY, FILLING, FULL}
  - function score_width(w) returning $clog2(w+1)
- One combinational sub-module, xnor_popcount:
  - Parameter WIDTH.
  - Inputs a and b; output the count of agreeing bits (bitwise XNOR then popcount).
  - Instantiated once; the top registers its output.

Test Plan:
1. Exact match. WIDTH=8, THRESH=8. Load pattern 8'b1011_0010, then stream 1,0,1,1,0,0,1,0 with in_valid continuously high. Required: out_valid first high the cycle after the 8th bit, with score=8, match=1, match_count=1; window_full high from that same cycle.
2. Threshold. Same pattern with THRESH=7. Stream 1,0,1,1,0,0,1,1. Required: score=7, match=1. With THRESH=8 the same stream gives match=0 and match_count=0.
3. Gaps and sliding. Stream 9 bits with in_valid low for 3 cycles between bits 4 and 5. Required: no out_valid during the gaps, exactly 2 out_valid pulses, and the 2nd score is computed on bits 2..9.
4. Clear mid-fill. clear asserted with in_valid high after 5 bits. Required: that bit is dropped, window_full=0, match_count=0, and the next out_valid comes only after 8 further accepts.
5. Saturation and pattern swap. CNT_W=2 with 5 consecutive matches. Required: match_count reaches 3 and holds at 3. Then assert pattern_load together with an accept: that bit is scored against the old pattern and the next bit against the new one.
6. Async reset mid-stream. Drop rst_n for half a cycle while FULL. Required: all outputs are 0 immediately, without waiting for a clock edge, and the pattern reads back as 0.

Source files
------------

// File: rtl/xnor_pkg.sv
// Shared types and helpers for the streaming XNOR correlator.
package xnor_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } fill_state_t;

   function automatic int score_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational agreement counter: bitwise XNOR of a and b, then popcount.
module xnor_popcount
   import xnor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   output logic [$clog2(WIDTH+1)-1:0]   count
);

   localparam int SW = score_width(WIDTH);

   logic [WIDTH-1:0] agree_s;

   // XNOR then sum each agreeing bit at full score width
   always_comb begin
      agree_s = ~(a ^ b);
      count   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         count = count + SW'(agree_s[i]);
      end
   end

endmodule

// File: rtl/xnor_correlator.sv
// Streaming XNOR correlator: serial window vs. programmable pattern with
// registered agreement score, threshold match and saturating match counter.
module xnor_correlator
   import xnor_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int THRESH = WIDTH,
   parameter int CNT_W  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         pattern_load,
   input  logic [WIDTH-1:0]             pattern_in,
   input  logic                         in_valid,
   input  logic                         in_bit,
   output logic                         out_valid,
   output logic [$clog2(WIDTH+1)-1:0]   score,
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic                         window_full
);

   localparam int             SW       = score_width(WIDTH);
   localparam logic [SW-1:0]  WIDTH_C  = SW'(WIDTH);
   localparam logic [SW-1:0]  THRESH_C = SW'(THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   fill_state_t       state_r, state_s;
   logic [SW-1:0]     fill_r, fill_s;
   logic [WIDTH-1:0]  win_r, win_s, pat_r;
   logic [SW-1:0]     agree_s;
   logic              accept_s, emit_s, match_s;

   assign accept_s = in_valid & ~clear;
   assign win_s    = {win_r[WIDTH-2:0], in_bit};
   assign match_s  = (agree_s >= THRESH_C);

   // Scores the window including the incoming bit against the current pattern
   xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
      .a     (win_s),
      .b     (pat_r),
      .count (agree_s)
   );

   // Fill-state next-state logic; emit when an accept leaves the window full
   always_comb begin
      state_s = state_r;
      fill_s  = fill_r;
      emit_s  = 1'b0;
      if (clear) begin
         state_s = EMPTY;
         fill_s  = '0;
      end else if (in_valid) begin
         case (state_r)
            EMPTY: begin
               fill_s  = SW'(1);
               state_s = FILLING;
            end
            FILLING: begin
               fill_s = fill_r + SW'(1);
               if (fill_s == WIDTH_C) begin
                  state_s = FULL;
               end else begin
                  state_s = FILLING;
               end
            end
            FULL: begin
               state_s = FULL;
            end
            default: begin
               state_s = EMPTY;
               fill_s  = '0;
            end
         endcase
         emit_s = (state_s == FULL);
      end else begin
         emit_s = 1'b0;
      end
   end

   // State, fill counter, window and pattern registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= EMPTY;
         fill_r      <= '0;
         win_r       <= '0;
         pat_r       <= '0;
         window_full <= 1'b0;
      end else begin
         state_r     <= state_s;
         fill_r      <= fill_s;
         window_full <= (state_s == FULL);
         if (pattern_load) begin
            pat_r <= pattern_in;
         end else begin
            pat_r <= pat_r;
         end
         if (clear) begin
            win_r <= '0;
         end else if (accept_s) begin
            win_r <= win_s;
         end else begin
            win_r <= win_r;
         end
      end
   end

   // Registered outputs; score deliberately holds when no pulse is issued
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         score       <= '0;
         match       <= 1'b0;
         match_count <= '0;
      end else if (clear) begin
         out_valid   <= 1'b0;
         match       <= 1'b0;
         match_count <= '0;
      end else if (emit_s) begin
         out_valid <= 1'b1;
         score     <= agree_s;
         match     <= match_s;
         if (match_s && (match_count != CNT_MAX)) begin
            match_count <= match_count + CNT_W'(1);
         end else begin
            match_count <= match_count;
         end
      end else begin
         out_valid <= 1'b0;
         match     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_xnor_correlator.sv
// Scoreboard bench for xnor_correlator: three instances (exact, THRESH=7, CNT_W=2)
// share directed stimulus; per-instance monitors pop expected outputs on out_valid.
module tb_xnor_correlator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear = 1'b0;
   logic       pattern_load = 1'b0;
   logic [7:0] pattern_in = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;

   logic        ov   [3];
   logic [3:0]  sc   [3];
   logic        mt   [3];
   logic [15:0] mcnt [3];
   logic        wf   [3];
   logic [15:0] mcnt0, mcnt1;
   logic [1:0]  mcnt2;

   assign mcnt[0] = mcnt0;
   assign mcnt[1] = mcnt1;
   assign mcnt[2] = {14'd0, mcnt2};

   always #5 clk = ~clk;

   xnor_correlator #(.WIDTH(8), .THRESH(8), .CNT_W(16)) dut_exact (
      .clk(clk), .rst_n(rst_n), .clear(clear), .pattern_load(pattern_load),
      .pattern_in(pattern_in), .in_valid(in_valid), .in_bit(in_bit),
      .out_valid(ov[0]), .score(sc[0]), .match(mt[0]), .match_count(mcnt0),
      .window_full(wf[0]));

   xnor_correlator #(.WIDTH(8), .THRESH(7), .CNT_W(16)) dut_th7 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .pattern_load(pattern_load),
      .pattern_in(pattern_in), .in_valid(in_valid), .in_bit(in_bit),
      .out_valid(ov[1]), .score(sc[1]), .match(mt[1]), .match_count(mcnt1),
      .window_full(wf[1]));

   xnor_correlator #(.WIDTH(8), .THRESH(8), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clear(clear), .pattern_load(pattern_load),
      .pattern_in(pattern_in), .in_valid(in_valid), .in_bit(in_bit),
      .out_valid(ov[2]), .score(sc[2]), .match(mt[2]), .match_count(mcnt2),
      .window_full(wf[2]));

   typedef struct {
      logic [3:0]  score;
      logic        match;
      logic [15:0] cnt;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int total = 0;
   int bad   = 0;
   int fill_m = 0;
   int mc_m  [3] = '{0, 0, 0};
   int th    [3] = '{8, 7, 8};
   int max_m [3] = '{65535, 65535, 3};

   task automatic push(input int k, input exp_t e);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, got, want);
      end
   endtask

   // One clock of stimulus; expected outputs come from the hand-given score
   task automatic step(input logic clr, input logic ld, input logic [7:0] p,
                       input logic v, input logic b, input int exp_sc);
      exp_t e;
      logic m;
      clear = clr; pattern_load = ld; pattern_in = p; in_valid = v; in_bit = b;
      if (clr) begin
         fill_m = 0;
         for (int k = 0; k < 3; k++) mc_m[k] = 0;
      end else if (v) begin
         if (fill_m < 8) fill_m++;
         if (fill_m == 8) begin
            for (int k = 0; k < 3; k++) begin
               m = (exp_sc >= th[k]);
               if (m && mc_m[k] < max_m[k]) mc_m[k]++;
               e.score = 4'(exp_sc);
               e.match = m;
               e.cnt   = 16'(mc_m[k]);
               push(k, e);
            end
         end
      end
      @(posedge clk);
      #1;
      clear = 1'b0; pattern_load = 1'b0; in_valid = 1'b0;
   endtask

   // Streams the low n bits of bits, oldest first; only the last may produce output
   task automatic send_bits(input logic [7:0] bits, input int n, input int sc_last);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, bits[n-1-i], (i == n-1) ? sc_last : 0);
      end
   endtask

   task automatic mon(input int k, input logic [3:0] s, input logic m,
                      input logic [15:0] c, input logic w);
      exp_t e;
      bit   have;
      have = 1'b0;
      case (k)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      total++;
      if (!have) begin
         bad++;
         $display("FAIL unexpected_out dut%0d: got out_valid=1 score=%0d want out_valid=0", k, s);
      end else if (s !== e.score || m !== e.match || c !== e.cnt || w !== 1'b1) begin
         bad++;
         $display("FAIL out dut%0d: got score=%0d match=%0b cnt=%0d full=%0b want score=%0d match=%0b cnt=%0d full=1",
                  k, s, m, c, w, e.score, e.match, e.cnt);
      end
   endtask

   always @(negedge clk) if (ov[0] === 1'b1) mon(0, sc[0], mt[0], mcnt[0], wf[0]);
   always @(negedge clk) if (ov[1] === 1'b1) mon(1, sc[1], mt[1], mcnt[1], wf[1]);
   always @(negedge clk) if (ov[2] === 1'b1) mon(2, sc[2], mt[2], mcnt[2], wf[2]);

   initial begin
      #12;
      for (int k = 0; k < 3; k++) begin
         chk("reset_out_valid", 16'(ov[k]), 16'd0);
         chk("reset_score", 16'(sc[k]), 16'd0);
         chk("reset_match_count", mcnt[k], 16'd0);
         chk("reset_window_full", 16'(wf[k]), 16'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Exact match on pattern 1011_0010
      step(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 0);
      send_bits(8'b0101_1001, 7, 0);
      chk("not_full_after_7", 16'(wf[0]), 16'd0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8);
      for (int k = 0; k < 3; k++) chk("full_after_8", 16'(wf[k]), 16'd1);
      chk("exact_count", mcnt[0], 16'd1);

      // Threshold: one disagreeing bit
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      send_bits(8'b1011_0011, 8, 7);

      // Gaps and sliding: scores 2 then 8
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      send_bits(8'b0000_0101, 4, 0);
      repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      send_bits(8'b0000_1001, 4, 2);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8);

      // Clear mid-fill with a coincident accept that must be dropped
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      send_bits(8'b0001_1111, 5, 0);
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      for (int k = 0; k < 3; k++) begin
         chk("clear_window_full", 16'(wf[k]), 16'd0);
         chk("clear_match_count", mcnt[k], 16'd0);
      end
      send_bits(8'hB2, 8, 8);

      // Clear with pattern load, then saturation on all-ones
      step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
      send_bits(8'hFF, 8, 8);
      repeat (4) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8);
      chk("sat_count", mcnt[2], 16'd3);
      chk("wide_count", mcnt[0], 16'd5);
      step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1);

      // Async reset during a valid output pulse
      in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      #1;
      chk("pre_reset_valid", 16'(ov[0]), 16'd1);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("async_out_valid", 16'(ov[k]), 16'd0);
         chk("async_score", 16'(sc[k]), 16'd0);
         chk("async_match", 16'(mt[k]), 16'd0);
         chk("async_match_count", mcnt[k], 16'd0);
         chk("async_window_full", 16'(wf[k]), 16'd0);
      end
      fill_m = 0;
      for (int k = 0; k < 3; k++) mc_m[k] = 0;
      #4;
      rst_n = 1'b1;
      #4;
      // Pattern reset to zero: 0000_0001 agrees in 7 bits
      send_bits(8'b0000_0001, 8, 7);

      repeat (3) @(posedge clk);
      #1;
      chk("q0_drained", 16'(q0.size()), 16'd0);
      chk("q1_drained", 16'(q1.size()), 16'd0);
      chk("q2_drained", 16'(q2.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
